block_accum: RTL
================

# block_accum

Parametrised, sequential successor to the combinational block adder. It owns the `M x N` result matrix and accumulates one `BLK_R x BLK_C` partial-product block at a time into it at (`start_row`, `start_col`), using `LANES` `fadd` units per cycle. It provides a start/busy/done handshake, an overwrite mode, a clear command, out-of-bounds masking and a registered read port. It sits between the block multiplier and the result read-out logic in the matrix-multiply datapath.

## Interface
Parameters:
- `DATA_W`, 16: element width; IEEE half-precision, matching `fadd`.
- `M`, 8: result rows.
- `N`, 8: result columns.
- `BLK_R`, 4: block rows.
- `BLK_C`, 4: block columns.
- `LANES`, 4: elements processed per cycle, 1..`BLK_R*BLK_C`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  zero the whole result matrix; honoured only in IDLE.
- `start`  in  1  request a block operation; honoured only in IDLE.
- `mode`  in  1  0 = accumulate (`buf + blk`), 1 = overwrite (`buf = blk`); sampled at accept.
- `start_row`  in  10  top row of the block in the result matrix; sampled at accept.
- `start_col`  in  10  left column of the block; sampled at accept.
- `blk_data`  in  `BLK_R*BLK_C*DATA_W`  flattened row-major block; element `e` is at bits `[e*DATA_W +: DATA_W]`. Sampled at accept.
- `busy`  out  1  high while an operation is in progress, up to and including the done cycle.
- `done`  out  1  one-cycle pulse when the operation completes.
- `oob_err`  out  1  sticky out-of-bounds flag; see Configuration.
- `rd_addr`  in  `$clog2(M*N)`  row-major read address.
- `rd_data`  out  `DATA_W`  registered read data.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `clear` has priority: all `M*N` entries are written to 0 in one cycle, and `start` in the same cycle is dropped.
  - Otherwise `start` is accepted: the block, mode and origin are latched, the beat counter is set to 0, and the FSM moves to RUN.
- RUN, beat `b` (0..`BEATS-1`, where `BEATS = ceil(BLK_R*BLK_C/LANES)`):
  - Lane `l` handles element `e = b*LANES + l`.
  - If `e >= BLK_R*BLK_C`, the lane is idle.
  - Otherwise `r = start_row + e/BLK_C` and `c = start_col + e%BLK_C`.
  - If `r < M` and `c < N`, entry `r*N+c` is written with `fadd(buf[r*N+c], blk[e])` (accumulate) or `blk[e]` (overwrite).
  - Otherwise the element is skipped and the buffer is untouched.
- The last beat moves the FSM to DONE; DONE returns to IDLE after one cycle.
- `start` and `clear` are ignored outside IDLE (no queueing).
- Lanes within one block never address the same entry, so there are no intra-beat write conflicts.
- Read port:
  - `rd_data <= buf[rd_addr]` every cycle in all states.
  - Read-before-write: a same-cycle write is visible one cycle later.
  - An out-of-range `rd_addr` returns 0.
- Reset, in any state including mid-RUN:
  - FSM returns to IDLE; the in-flight operation is abandoned.
  - All buffer entries are zeroed.
  - `busy`, `done`, `oob_err` and `rd_data` are all 0.

## Timing
- Accept at edge T:
  - RUN beats occupy cycles T+1..T+`BEATS`.
  - DONE is at cycle T+`BEATS`+1.
  - `busy` is high for cycles T+1..T+`BEATS`+1.
- Defaults (16 elements, 4 lanes): 4 beats; `done` at T+5; the next `start` can be accepted at T+6.
- A `start` held high continuously is re-accepted on the first IDLE cycle after DONE.
- `clear` completes in one cycle; `busy` stays 0 during it.
- Read latency is 1 cycle.

## Configuration
- `BLOCK_ACCUM_OOB_ERR_EN` defined:
  - `oob_err` sets when any element is skipped for out-of-bounds.
  - It stays set until `rst` or an accepted `clear`.
  - If a `clear` is accepted in the same cycle that a skip would set the flag, set wins.
- `BLOCK_ACCUM_OOB_ERR_EN` not defined:
  - `oob_err` is tied to 0.
  - Masking of out-of-bounds elements is unchanged.

## Test plan
- Reset, then `start`, mode 0, origin (0,0), all elements 0x3C00 (1.0):
  - `done` at T+5.
  - Reading entries 0..3, 8..11, 16..19, 24..27 returns 0x3C00; all other entries return 0.
- Repeat the same block in mode 0 → those entries read 0x4000 (2.0). Then one mode-1 block of 0x4200 (3.0) → those entries read 0x4200.
- Origin (6,6) with a 4x4 block of 0x3C00:
  - Only entries 54, 55, 62, 63 become 0x3C00.
  - `oob_err` = 1 with the macro defined, 0 without it.
- `start` pulsed at T+2 during RUN, and `clear` at T+3:
  - Both are ignored.
  - Exactly one `done` pulse occurs; the buffer is unchanged by the `clear`.
- `clear` and `start` asserted together in IDLE:
  - The buffer becomes all 0.
  - No `busy` and no `done`.
  - `oob_err` drops to 0.
- `rst` asserted at T+2 mid-RUN:
  - Next cycle: `busy` = 0, `done` = 0, all entries read 0.
  - A subsequent `start` completes normally.

Source files
------------

// File: rtl/block_accum.sv
// Sequential block accumulator: owns the M x N fp16 result matrix and folds one
// BLK_R x BLK_C block into it, LANES elements per beat. Optional: BLOCK_ACCUM_OOB_ERR_EN.
module block_accum #(
   parameter int DATA_W = 16,
   parameter int M      = 8,
   parameter int N      = 8,
   parameter int BLK_R  = 4,
   parameter int BLK_C  = 4,
   parameter int LANES  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          start,
   input  logic                          mode,
   input  logic [9:0]                    start_row,
   input  logic [9:0]                    start_col,
   input  logic [BLK_R*BLK_C*DATA_W-1:0] blk_data,
   output logic                          busy,
   output logic                          done,
   output logic                          oob_err,
   input  logic [$clog2(M*N)-1:0]        rd_addr,
   output logic [DATA_W-1:0]             rd_data
);
   localparam int ELEMS = BLK_R * BLK_C;
   localparam int BEATS = (ELEMS + LANES - 1) / LANES;
   localparam int BW    = $clog2(BEATS + 1);
   localparam int AW    = $clog2(M * N);
   localparam int EW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // Half-precision add, round-to-nearest-even; subnormals, inf and NaN handled.
   function automatic logic [15:0] f_fadd(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] x, y, res;
      logic [5:0]  ex, ey, d;
      logic [13:0] mx, my;
      logic [14:0] s;
      logic [11:0] rm;
      logic        st, sub;
      res = 16'h0000;
      if ((a[14:10] == 5'h1F && a[9:0] != 10'h0) || (b[14:10] == 5'h1F && b[9:0] != 10'h0))
         res = 16'h7E00;
      else if (a[14:10] == 5'h1F && b[14:10] == 5'h1F)
         res = (a[15] != b[15]) ? 16'h7E00 : a;
      else if (a[14:10] == 5'h1F)
         res = a;
      else if (b[14:10] == 5'h1F)
         res = b;
      else begin
         if (a[14:0] < b[14:0]) begin x = b; y = a; end
         else begin x = a; y = b; end
         sub = x[15] ^ y[15];
         ex  = (x[14:10] == 5'h0) ? 6'd1 : {1'b0, x[14:10]};
         ey  = (y[14:10] == 5'h0) ? 6'd1 : {1'b0, y[14:10]};
         mx  = {(x[14:10] != 5'h0), x[9:0], 3'b000};
         my  = {(y[14:10] != 5'h0), y[9:0], 3'b000};
         d   = ex - ey;
         st  = 1'b0;
         for (int i = 0; i < 14; i++) begin
            if (6'(i) < d) begin
               st = st | my[0];
               my = my >> 1;
            end
         end
         my[0] = my[0] | st;
         s = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
         if (s == 15'h0)
            res = {x[15] & ~sub, 15'h0};
         else begin
            if (s[14]) begin
               s  = {1'b0, s[14:2], s[1] | s[0]};
               ex = ex + 6'd1;
            end
            for (int i = 0; i < 13; i++) begin
               if (!s[13] && ex > 6'd1) begin
                  s  = s << 1;
                  ex = ex - 6'd1;
               end
            end
            rm = {1'b0, s[13:3]} + {11'h0, s[2] & (s[1] | s[0] | s[3])};
            if (rm[11]) begin
               rm = rm >> 1;
               ex = ex + 6'd1;
            end
            if (ex >= 6'd31) res = {x[15], 5'h1F, 10'h0};
            else             res = {x[15], (rm[10] ? ex[4:0] : 5'h0), rm[9:0]};
         end
      end
      return res;
   endfunction

   state_t            r_state;
   logic [BW-1:0]     r_beat;
   logic              r_mode;
   logic [9:0]        r_row;
   logic [9:0]        r_col;
   logic [DATA_W-1:0] r_blk [ELEMS];
   logic [DATA_W-1:0] r_buf [M*N];
   logic              r_busy;
   logic              r_done;
   logic              r_oob;
   logic [DATA_W-1:0] r_rd_data;

   logic [AW-1:0]     w_idx   [LANES];
   logic [DATA_W-1:0] w_wdata [LANES];
   logic              w_we    [LANES];
   logic              w_skip;

   // Per-lane target address and write value for the current beat.
   always_comb begin
      int e, rr, cc;
      w_skip = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         w_we[l]    = 1'b0;
         w_idx[l]   = '0;
         w_wdata[l] = '0;
         e  = int'(r_beat) * LANES + l;
         rr = int'(r_row) + e / BLK_C;
         cc = int'(r_col) + e % BLK_C;
         if (e < ELEMS) begin
            if (rr < M && cc < N) begin
               w_we[l]    = 1'b1;
               w_idx[l]   = AW'(rr * N + cc);
               w_wdata[l] = r_mode ? r_blk[EW'(e)]
                                   : f_fadd(r_buf[AW'(rr * N + cc)], r_blk[EW'(e)]);
            end else begin
               w_skip = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_beat    <= '0;
         r_mode    <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_oob     <= 1'b0;
         r_rd_data <= '0;
         for (int i = 0; i < ELEMS; i++) r_blk[i] <= '0;
         for (int i = 0; i < M * N; i++) r_buf[i] <= '0;
      end else begin
         r_rd_data <= (int'(rd_addr) < M * N) ? r_buf[rd_addr] : '0;
         case (r_state)
            S_IDLE: begin
               if (clear) begin
                  for (int i = 0; i < M * N; i++) r_buf[i] <= '0;
                  r_oob <= 1'b0;
               end else if (start) begin
                  r_mode  <= mode;
                  r_row   <= start_row;
                  r_col   <= start_col;
                  r_beat  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
                  for (int e = 0; e < ELEMS; e++) r_blk[e] <= blk_data[e*DATA_W +: DATA_W];
               end
            end
            S_RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  if (w_we[l]) r_buf[w_idx[l]] <= w_wdata[l];
               end
               if (w_skip) r_oob <= 1'b1;
               if (r_beat == BW'(BEATS - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign rd_data = r_rd_data;
`ifdef BLOCK_ACCUM_OOB_ERR_EN
   assign oob_err = r_oob;
`else
   assign oob_err = 1'b0 & r_oob;
`endif

endmodule
